// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: arbitrates two writeback sources onto one register-file write port.
// Optional feature macro: RF_ARB_STARVE_GUARD_EN enables the port-1 starvation guard
// (wait counter plus FORCE1 state). Without it, port 0 always has strict priority.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   valid0/ready0/addr0/data0 : pipeline writeback request (high priority)
//   valid1/ready1/addr1/data1 : multi-cycle unit writeback request
//   regWrite, writeRegister,
//   writeData                 : registered register-file write, one cycle after accept
//   grant1Pending             : valid1 high and not accepted this cycle
module regfile_write_arbiter #(
    parameter int WordLen  = 32,
    parameter int AddrBits = 5,
    parameter int MaxWait  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid0,
    output logic                ready0,
    input  logic [AddrBits-1:0] addr0,
    input  logic [WordLen-1:0]  data0,
    input  logic                valid1,
    output logic                ready1,
    input  logic [AddrBits-1:0] addr1,
    input  logic [WordLen-1:0]  data1,
    output logic                regWrite,
    output logic [AddrBits-1:0] writeRegister,
    output logic [WordLen-1:0]  writeData,
    output logic                grant1Pending
);
    if (MaxWait < 1 || MaxWait > 15) begin : g_bad_max_wait
        $error("MaxWait must be in 1..15");
    end
    logic                acc0, acc1;
    logic                reg_write_d, reg_write_q;
    logic [AddrBits-1:0] write_register_d, write_register_q;
    logic [WordLen-1:0]  write_data_d, write_data_q;
`ifdef RF_ARB_STARVE_GUARD_EN
    typedef enum logic {NORMAL, FORCE1} state_t;
    localparam logic [3:0] WaitLimit = 4'(MaxWait);
    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    // FORCE1 hands the port to unit 1 unconditionally so it cannot starve.
    always_comb begin
        ready0 = !rst && valid0 && state_q == NORMAL;
        ready1 = !rst && (state_q == FORCE1 || (valid1 && !valid0));
    end
    // Entering FORCE1 on the same edge the counter hits the limit gives ready1
    // in the MaxWait-th cycle after the first refusal.
    always_comb begin
        wait_d  = (!valid1 || acc1) ? 4'd0 : (wait_q == WaitLimit ? wait_q : wait_q + 4'd1);
        state_d = acc1 ? NORMAL : (wait_d == WaitLimit ? FORCE1 : state_q);
    end
`else
    always_comb begin
        ready0 = !rst && valid0;
        ready1 = !rst && valid1 && !valid0;
    end
`endif
    assign acc0          = valid0 && ready0;
    assign acc1          = valid1 && ready1;
    assign grant1Pending = valid1 && !ready1;
    // Register 0 is hardwired: its request is consumed but never written.
    always_comb begin
        reg_write_d      = (acc0 && addr0 != '0) || (acc1 && addr1 != '0);
        write_register_d = acc0 ? addr0 : acc1 ? addr1 : write_register_q;
        write_data_d     = acc0 ? data0 : acc1 ? data1 : write_data_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
`ifdef RF_ARB_STARVE_GUARD_EN
            state_q          <= NORMAL;
            wait_q           <= 4'd0;
`endif
        end else begin
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
`ifdef RF_ARB_STARVE_GUARD_EN
            state_q          <= state_d;
            wait_q           <= wait_d;
`endif
        end
    end
    assign regWrite      = reg_write_q;
    assign writeRegister = write_register_q;
    assign writeData     = write_data_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random checks of regfile_write_arbiter against a reference model.
module tb_regfile_write_arbiter;
    localparam int MW = 4;
`ifdef RF_ARB_STARVE_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1, v0 = 1'b0, v1 = 1'b0;
    logic [4:0]  a0 = '0, a1 = '0;
    logic [31:0] d0 = '0, d1 = '0;
    logic        ready0, ready1, regWrite, grant1Pending;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [31:0] rf [32];
    int          n_vec = 0, n_err = 0, refused = 0, first;
    bit          m_acc0, m_acc1;
    logic        e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;

    regfile_write_arbiter #(.WordLen(32), .AddrBits(5), .MaxWait(MW)) dut (
        .clk(clk), .rst(rst),
        .valid0(v0), .ready0(ready0), .addr0(a0), .data0(d0),
        .valid1(v1), .ready1(ready1), .addr1(a1), .data1(d1),
        .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
        .grant1Pending(grant1Pending)
    );

    always #5 clk = ~clk;

    // Register file that writes mid-cycle on negedge.
    always @(negedge clk) if (regWrite) rf[writeRegister] <= writeData;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: check handshakes against the model, clock, then check the write port.
    task automatic cycle();
        bit frc, r0, r1;
        #1;
        frc = Guard && refused >= MW;
        r0  = !rst && v0 && !frc;
        r1  = !rst && (frc || (v1 && !v0));
        chk("ready0", ready0, r0);
        chk("ready1", ready1, r1);
        chk("grant1Pending", grant1Pending, v1 && !r1);
        m_acc0 = v0 && r0;
        m_acc1 = v1 && r1;
        @(posedge clk);
        if (rst) begin
            e_rw = 1'b0; e_wr = '0; e_wd = '0; refused = 0;
        end else begin
            if (m_acc0) begin
                e_rw = a0 != 0; e_wr = a0; e_wd = d0;
            end else if (m_acc1) begin
                e_rw = a1 != 0; e_wr = a1; e_wd = d1;
            end else e_rw = 1'b0;
            refused = (v1 && !m_acc1) ? (refused < MW ? refused + 1 : MW) : 0;
        end
        #1;
        chk("regWrite", regWrite, e_rw);
        chk("writeRegister", writeRegister, e_wr);
        chk("writeData", writeData, e_wd);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        @(negedge clk);
        // Reset with both requests pending: nothing accepted.
        rst = 1'b1; v0 = 1'b1; a0 = 5'd4; d0 = 32'h44; v1 = 1'b1; a1 = 5'd6; d1 = 32'h66;
        cycle();
        cycle();
        chk("rst_regWrite", regWrite, 0);
        chk("rst_writeData", writeData, 0);
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
        cycle();
        chk("post_rst_no_pulse", regWrite, 0);
        // Single accept.
        v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEADBEEF;
        cycle();
        chk("single_regWrite", regWrite, 1);
        chk("single_reg", writeRegister, 5);
        chk("single_data", writeData, 32'hDEADBEEF);
        v0 = 1'b0;
        cycle();
        chk("single_pulse_end", regWrite, 0);
        // Collision: port 0 first, then port 1.
        v0 = 1'b1; a0 = 5'd3; d0 = 32'hA3A3A3A3; v1 = 1'b1; a1 = 5'd7; d1 = 32'hB7B7B7B7;
        cycle();
        chk("coll_x3_first", writeRegister, 3);
        v0 = 1'b0;
        cycle();
        chk("coll_x7_second", writeRegister, 7);
        v1 = 1'b0;
        cycle();
        cycle();
        chk("coll_rf_x3", rf[3], 32'hA3A3A3A3);
        chk("coll_rf_x7", rf[7], 32'hB7B7B7B7);
        // Write to x0 is consumed but suppressed.
        v1 = 1'b1; a1 = 5'd0; d1 = 32'h1234;
        cycle();
        chk("x0_regWrite", regWrite, 0);
        chk("x0_data", writeData, 32'h1234);
        v1 = 1'b0;
        cycle();
        cycle();
        chk("x0_readback", rf[0], 0);
        // Starvation pressure from port 0.
        v0 = 1'b1; a0 = 5'd1; d0 = 32'h11; v1 = 1'b1; a1 = 5'd2; d1 = 32'h22;
`ifdef RF_ARB_STARVE_GUARD_EN
        first = -1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (m_acc1) begin
                first = i;
                break;
            end
            d0 = d0 + 1;
        end
        v1 = 1'b0;
        chk("starve_force_within5", 32'(first >= 0 && first <= 4), 1);
        chk("starve_port1_write", writeRegister, 2);
        cycle();
        chk("starve_port0_resume", writeRegister, 1);
`else
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("no_guard_ready1_low", ready1, 0);
            d0 = d0 + 1;
        end
        v1 = 1'b0;
`endif
        v0 = 1'b0;
        cycle();
        // Random traffic; a request holds its payload until accepted.
        m_acc0 = 1'b0; m_acc1 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!v0 || m_acc0) begin
                v0 = $urandom_range(0, 2) != 0; a0 = 5'($urandom_range(0, 31)); d0 = $urandom;
            end
            if (!v1 || m_acc1) begin
                v1 = $urandom_range(0, 1) != 0; a1 = 5'($urandom_range(0, 31)); d1 = $urandom;
            end
            cycle();
        end
        // Reset arriving during an accept cycle.
        v1 = 1'b0; v0 = 1'b1; a0 = 5'd9; d0 = 32'h99;
        cycle();
        d0 = 32'h9A;
        rst = 1'b1;
        cycle();
        chk("midrst_regWrite", regWrite, 0);
        chk("midrst_reg", writeRegister, 0);
        chk("midrst_data", writeData, 0);
        rst = 1'b0; v0 = 1'b0;
        cycle();
        chk("midrst_no_pulse", regWrite, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter WordLen, default 32, meaning data width of a register-file word.
REQ-002 SHALL have parameter AddrBits, default 5, meaning register index width for 32 registers.
REQ-003 SHALL have parameter MaxWait, default 4, meaning port-1 starvation limit in cycles, legal range 1..15.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have ports valid0 / ready0, input / output, 1 each: pipeline writeback request handshake.
REQ-007 SHALL have ports addr0 / data0, input, AddrBits / WordLen: pipeline writeback destination and value.
REQ-008 SHALL have ports valid1 / ready1, input / output, 1 each: multi-cycle unit writeback request handshake.
REQ-009 SHALL have ports addr1 / data1, input, AddrBits / WordLen: multi-cycle unit destination and value.
REQ-010 SHALL have port regWrite, output, 1: registered write enable to the register file.
REQ-011 SHALL have ports writeRegister / writeData, output, AddrBits / WordLen: registered write index and data.
REQ-012 SHALL have port grant1Pending, output, 1: high while valid1 is high and not yet accepted.

Function
REQ-013 SHALL accept a request on port n only in the cycle where validn and readyn are both high.
REQ-014 SHALL assert at most one of ready0 and ready1 in any cycle; ready depends combinationally on valid0, valid1 and the FSM state.
REQ-015 SHALL, when only one port is valid, assert ready for that port in the same cycle.
REQ-016 SHALL, when both ports are valid in state NORMAL, grant port 0.
REQ-017 SHALL, on an accepted request, drive regWrite, writeRegister and writeData from that request on the next posedge (latency exactly one cycle); regWrite is high for exactly one cycle per accept.
REQ-018 SHALL accept a request addressed to register 0 and then hold regWrite low for it; writeRegister and writeData still update.
REQ-019 SHALL keep regWrite low and writeRegister and writeData unchanged in any cycle with no accept.
REQ-020 SHALL implement FSM states NORMAL and FORCE1; NORMAL goes to FORCE1 when the wait counter reaches MaxWait, and FORCE1 returns to NORMAL on the cycle port 1 is accepted.
REQ-021 SHALL, in FORCE1, assert ready1 and deassert ready0 regardless of valid0.
REQ-022 SHALL maintain a 4-bit wait counter: +1 each cycle valid1 is high and not accepted, cleared on a port-1 accept or when valid1 is low, saturating at MaxWait.
REQ-023 SHALL, when both requests target the same nonzero register, write them in grant order so that the last granted value persists.
REQ-024 SHALL deliver all output changes on posedge so that a register file writing on negedge samples stable values mid-cycle.

Reset
REQ-025 SHALL, while rst is high at posedge, set regWrite=0, writeRegister=0, writeData=0, wait counter=0 and state NORMAL.
REQ-026 SHALL hold ready0 and ready1 low while rst is high, accept nothing, and discard any request in flight when rst asserts.
REQ-027 SHALL resume arbitration on the first posedge after rst deasserts, with no spurious regWrite pulse.

Configuration
REQ-028 SHALL, with macro RF_ARB_STARVE_GUARD_EN defined, implement the wait counter and FORCE1 per REQ-020..022.
REQ-029 SHALL, without RF_ARB_STARVE_GUARD_EN, use strict port-0 priority only; the FSM stays in NORMAL permanently, no wait counter exists, and grant1Pending is still driven.

Verification
REQ-030 SHALL cover single accept: valid0=1, addr0=5, data0=0xDEADBEEF for 1 cycle -> next cycle regWrite=1, writeRegister=5, writeData=0xDEADBEEF, then regWrite=0.
REQ-031 SHALL cover a collision: valid0 and valid1 both high, addr0=3, addr1=7 -> ready0=1, ready1=0; then valid0 low -> port 1 accepted the next cycle, and writes reach x3 then x7.
REQ-032 SHALL cover starvation with the guard enabled and MaxWait=4: valid0 and valid1 held high -> FORCE1 entered and ready1=1 within 5 cycles, and port 0 resumes afterward.
REQ-033 SHALL cover starvation with the guard disabled under the same stimulus -> ready1 stays 0 for 20 cycles.
REQ-034 SHALL cover an x0 write: valid1=1, addr1=0, data1=0x1234 -> accept occurs, regWrite stays 0, and x0 reads back 0.
REQ-035 SHALL cover reset mid-operation: rst high during an accept cycle -> next cycle regWrite=0 and all outputs are 0.
